// File: rtl/lsu_mmio_mc_if.sv
// Request/response bus between the core pipeline and the load/store unit.
// The core drives the master side; the LSU drives the slave side.
interface lsu_mmio_mc_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [2:0]  ls_op_i;
  logic [31:0] addr_i;
  logic [31:0] st_data_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_data_o;
  logic        rsp_err_o;

  modport slave (
    input  req_valid_i, req_we_i, ls_op_i, addr_i, st_data_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o
  );

  modport master (
    output req_valid_i, req_we_i, ls_op_i, addr_i, st_data_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o
  );
endinterface

// File: rtl/lsu_mmio_mc.sv
// Multi-cycle load/store unit: data memory, LED/LCD/HEX output registers and
// switch input behind a valid/ready request and a one-cycle response pulse.
module lsu_mmio_mc #(
  parameter int DMEM_AW    = 10,
  parameter int NUM_HEX    = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  lsu_mmio_mc_if.slave          bus,
  input  logic [31:0]           sw_i,
  output logic [31:0]           io_ledr_o,
  output logic [31:0]           io_ledg_o,
  output logic [31:0]           io_lcd_o,
  output logic [32*NUM_HEX-1:0] io_hex_o
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;
  localparam logic [1:0] CNT_INIT = 2'(RD_LATENCY - 1);

  state_e      r_state, w_state_nxt;
  logic [1:0]  r_cnt, w_cnt_nxt;
  logic        r_we, r_err, r_is_dmem;
  logic [2:0]  r_op;
  logic [1:0]  r_lane;
  logic [31:0] r_io_rdata, r_mem_rdata;
  logic [31:0] r_ledr, r_ledg, r_lcd;
  logic [31:0] r_hex [NUM_HEX];
  logic [31:0] r_mem [2**DMEM_AW];

  logic        w_accept, w_hi_zero, w_op_ok, w_misal, w_err, w_store;
  logic        w_is_dmem, w_is_ledr, w_is_ledg, w_is_lcd, w_is_hex, w_is_sw;
  logic [13:0] w_waddr, w_hex_rel;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_io_rdata, w_raw, w_ext;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  function automatic logic [31:0] merge_be(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] v;
    v = old_v;
    for (int b = 0; b < 4; b++)
      if (be[b]) v[8*b +: 8] = new_v[8*b +: 8];
    return v;
  endfunction

  // Decoding works on word addresses; addr_i[1:0] only picks lanes.
  assign w_accept  = bus.req_valid_i && bus.req_ready_o;
  assign w_hi_zero = (bus.addr_i[31:16] == 16'h0);
  assign w_waddr   = bus.addr_i[15:2];
  assign w_hex_rel = w_waddr - 14'h1C08;
  assign w_is_dmem = w_hi_zero && ((w_waddr >> DMEM_AW) == 14'h0);
  assign w_is_ledr = w_hi_zero && (w_waddr == 14'h1C00);
  assign w_is_ledg = w_hi_zero && (w_waddr == 14'h1C04);
  assign w_is_lcd  = w_hi_zero && (w_waddr == 14'h1C20);
  assign w_is_sw   = w_hi_zero && (w_waddr == 14'h1E00);
  assign w_is_hex  = w_hi_zero && (w_waddr >= 14'h1C08) && (w_hex_rel < 14'(NUM_HEX));

  assign w_op_ok = bus.req_we_i ? (bus.ls_op_i <= 3'd2)
                                : ((bus.ls_op_i[1:0] != 2'b11) && (bus.ls_op_i != 3'b110));
  assign w_misal = ((bus.ls_op_i[1:0] == 2'b01) && bus.addr_i[0]) ||
                   ((bus.ls_op_i[1:0] == 2'b10) && (bus.addr_i[1:0] != 2'b00));
  assign w_err   = !w_op_ok || w_misal;
  assign w_store = w_accept && bus.req_we_i && !w_err;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = bus.st_data_i;
    case (bus.ls_op_i[1:0])
      2'b00: begin
        w_be    = 4'b0001 << bus.addr_i[1:0];
        w_wdata = {4{bus.st_data_i[7:0]}};
      end
      2'b01: begin
        w_be    = bus.addr_i[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{bus.st_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_io_rdata = '0;
    if (w_is_ledr) w_io_rdata = r_ledr;
    if (w_is_ledg) w_io_rdata = r_ledg;
    if (w_is_lcd)  w_io_rdata = r_lcd;
    if (w_is_sw)   w_io_rdata = sw_i;
    for (int i = 0; i < NUM_HEX; i++)
      if (w_is_hex && (w_hex_rel == 14'(i))) w_io_rdata = r_hex[i];
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ledr <= '0;
      r_ledg <= '0;
      r_lcd  <= '0;
      for (int i = 0; i < NUM_HEX; i++) r_hex[i] <= '0;
    end else if (w_store) begin
      if (w_is_ledr) r_ledr <= merge_be(r_ledr, w_wdata, w_be);
      if (w_is_ledg) r_ledg <= merge_be(r_ledg, w_wdata, w_be);
      if (w_is_lcd)  r_lcd  <= merge_be(r_lcd, w_wdata, w_be);
      for (int i = 0; i < NUM_HEX; i++)
        if (w_is_hex && (w_hex_rel == 14'(i))) r_hex[i] <= merge_be(r_hex[i], w_wdata, w_be);
    end
  end

  // NOTE: the data memory has no reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (w_store && w_is_dmem)
      for (int b = 0; b < 4; b++)
        if (w_be[b]) r_mem[w_waddr[DMEM_AW-1:0]][8*b +: 8] <= w_wdata[8*b +: 8];
    if (w_accept) r_mem_rdata <= r_mem[w_waddr[DMEM_AW-1:0]];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_we       <= 1'b0;
      r_err      <= 1'b0;
      r_is_dmem  <= 1'b0;
      r_op       <= '0;
      r_lane     <= '0;
      r_io_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_we       <= bus.req_we_i;
        r_err      <= w_err;
        r_is_dmem  <= w_is_dmem;
        r_op       <= bus.ls_op_i;
        r_lane     <= bus.addr_i[1:0];
        r_io_rdata <= w_io_rdata;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE:
        if (w_accept) begin
          if (!bus.req_we_i && !w_err && w_is_dmem) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = CNT_INIT;
          end else begin
            w_state_nxt = S_RESP;
          end
        end
      S_WAIT:
        if (r_cnt == 2'd0) w_state_nxt = S_RESP;
        else               w_cnt_nxt   = r_cnt - 2'd1;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_raw = r_is_dmem ? r_mem_rdata : r_io_rdata;
    case (r_lane)
      2'd0:    w_byte = w_raw[7:0];
      2'd1:    w_byte = w_raw[15:8];
      2'd2:    w_byte = w_raw[23:16];
      default: w_byte = w_raw[31:24];
    endcase
    w_half = r_lane[1] ? w_raw[31:16] : w_raw[15:0];
    case (r_op)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ext = {24'h0, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b101:  w_ext = {16'h0, w_half};
      default: w_ext = w_raw;
    endcase
    bus.req_ready_o = (r_state == S_IDLE);
    bus.rsp_valid_o = (r_state == S_RESP);
    bus.rsp_err_o   = bus.rsp_valid_o && r_err;
    bus.rsp_data_o  = (bus.rsp_valid_o && !r_we && !r_err) ? w_ext : '0;
  end

  assign io_ledr_o = r_ledr;
  assign io_ledg_o = r_ledg;
  assign io_lcd_o  = r_lcd;
  for (genvar g = 0; g < NUM_HEX; g++) begin : g_hex
    assign io_hex_o[32*g +: 32] = r_hex[g];
  end
endmodule

// File: tb/tb_lsu_mmio_mc.sv
// Self-checking bench for lsu_mmio_mc: directed vector table, hand-written
// latency/reset sequences and randomized traffic against a byte-level model.
module tb_lsu_mmio_mc;
  localparam int LAT   = 3;
  localparam int NHEX  = 12;
  localparam int AW    = 10;
  localparam int DMEM_BYTES = 4 * (2**AW);

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic [31:0] sw = '0;
  logic [31:0] ledr, ledg, lcd;
  logic [32*NHEX-1:0] hex;

  lsu_mmio_mc_if bus();

  lsu_mmio_mc #(.DMEM_AW(AW), .NUM_HEX(NHEX), .RD_LATENCY(LAT)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .bus(bus), .sw_i(sw),
    .io_ledr_o(ledr), .io_ledg_o(ledg), .io_lcd_o(lcd), .io_hex_o(hex)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int idle_bad = 0;

  typedef struct {
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] swv;
    logic [31:0] exp_d;
    logic        exp_e;
    int          exp_l;
  } vec_t;
  vec_t vecs[$];

  // Behavioural model: byte-addressed memory plus word-keyed IO registers.
  logic [7:0]  m_mem [int];
  logic [31:0] m_io  [int];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_io.delete();
    m_io[32'h7000] = '0;
    m_io[32'h7010] = '0;
    m_io[32'h7080] = '0;
    for (int i = 0; i < NHEX; i++) m_io[32'h7020 + 4*i] = '0;
  endtask

  task automatic model_req(input logic we, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] swv,
                           output logic [31:0] ed, output logic ee, output int el);
    int size, lane, w, kind;  // kind: 0 dmem, 1 io, 2 switch, 3 unmapped
    bit legal;
    logic [31:0] v;
    logic [7:0] bv;
    size  = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
    legal = we ? (op <= 3'd2) : (op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    ed = '0; ee = 1'b0; el = 1;
    if (!legal || (int'(addr[1:0]) % size) != 0) begin
      ee = 1'b1;
      return;
    end
    lane = int'(addr[1:0]);
    w    = int'(addr & 32'hFFFF_FFFC);
    if (addr < DMEM_BYTES)                      kind = 0;
    else if (addr < 32'h10000 && m_io.exists(w)) kind = 1;
    else if (addr < 32'h10000 && w == 32'h7800)  kind = 2;
    else                                         kind = 3;
    if (we) begin
      for (int b = 0; b < size; b++) begin
        if (kind == 0) m_mem[int'(addr) + b] = wd[8*b +: 8];
        if (kind == 1) begin
          v = m_io[w];
          v[8*(lane+b) +: 8] = wd[8*b +: 8];
          m_io[w] = v;
        end
      end
    end else begin
      v = '0;
      for (int b = 0; b < size; b++) begin
        case (kind)
          0:       bv = m_mem[int'(addr) + b];
          1:       bv = m_io[w][8*(lane+b) +: 8];
          2:       bv = swv[8*(lane+b) +: 8];
          default: bv = 8'h00;
        endcase
        v[8*b +: 8] = bv;
      end
      if (!op[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
      ed = v;
      if (kind == 0) el = LAT + 1;
    end
  endtask

  // Issue one request and wait for its response; lat counts cycles after accept.
  task automatic do_req(input logic we, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] swv,
                        output logic [31:0] rd, output logic er, output int lat, output int busy);
    int g;
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = we;
    bus.ls_op_i     = op;
    bus.addr_i      = addr;
    bus.st_data_i   = wd;
    sw              = swv;
    rd = '0; er = 1'b0; lat = -1; busy = 0;
    g = 0;
    while (!bus.req_ready_o && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (!bus.req_ready_o) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: ready stayed 0, required 1");
      bus.req_valid_i = 1'b0;
      return;
    end
    @(posedge clk);
    #1 bus.req_valid_i = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (!bus.req_ready_o) busy++;
      if (bus.rsp_valid_o) begin
        rd  = bus.rsp_data_o;
        er  = bus.rsp_err_o;
        lat = k;
        break;
      end else if (bus.rsp_data_o != '0 || bus.rsp_err_o) begin
        idle_bad++;
      end
    end
  endtask

  task automatic run(input string name, input logic we, input logic [2:0] op,
                     input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] swv,
                     input logic [31:0] exp_d, input logic exp_e, input int exp_l);
    logic [31:0] rd;
    logic er;
    int lat, busy;
    do_req(we, op, addr, wd, swv, rd, er, lat, busy);
    check({name, ".data"}, rd, exp_d);
    check({name, ".err"}, 32'(er), 32'(exp_e));
    check({name, ".lat"}, lat, exp_l);
  endtask

  function automatic vec_t mk(logic we, logic [2:0] op, logic [31:0] addr, logic [31:0] wd,
                              logic [31:0] swv, logic [31:0] exp_d, logic exp_e, int exp_l);
    vec_t v;
    v.we = we; v.op = op; v.addr = addr; v.wd = wd; v.swv = swv;
    v.exp_d = exp_d; v.exp_e = exp_e; v.exp_l = exp_l;
    return v;
  endfunction

  task automatic apply_reset();
    bus.req_valid_i = 1'b0;
    rst_ni = 1'b0;
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    model_reset();
  endtask

  task automatic check_io(input string tag);
    check({tag, ".ledr"}, ledr, m_io[32'h7000]);
    check({tag, ".ledg"}, ledg, m_io[32'h7010]);
    check({tag, ".lcd"},  lcd,  m_io[32'h7080]);
    for (int i = 0; i < NHEX; i++)
      check($sformatf("%s.hex%0d", tag, i), hex[32*i +: 32], m_io[32'h7020 + 4*i]);
  endtask

  initial begin
    logic [31:0] ed, rd;
    logic ee, er;
    int el, lat, busy, seen;

    bus.req_valid_i = 1'b0;
    bus.req_we_i    = 1'b0;
    bus.ls_op_i     = '0;
    bus.addr_i      = '0;
    bus.st_data_i   = '0;

    apply_reset();
    check("rst.ready", 32'(bus.req_ready_o), 32'd1);
    check("rst.rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    check("rst.rsp_data", bus.rsp_data_o, 32'd0);
    check("rst.rsp_err", 32'(bus.rsp_err_o), 32'd0);
    check_io("rst");

    // Directed vectors: store 1, load 0; op 0 lb/sb, 1 lh/sh, 2 lw/sw, 4 lbu, 5 lhu.
    vecs.push_back(mk(1, 3'd2, 32'h0000_0000, 32'h1122_3344, 0, 0, 0, 1));
    vecs.push_back(mk(1, 3'd2, 32'h0000_0010, 32'h8000_00FF, 0, 0, 0, 1));
    vecs.push_back(mk(0, 3'd0, 32'h0000_0010, 0, 0, 32'hFFFF_FFFF, 0, LAT+1));
    vecs.push_back(mk(0, 3'd4, 32'h0000_0010, 0, 0, 32'h0000_00FF, 0, LAT+1));
    vecs.push_back(mk(0, 3'd1, 32'h0000_0010, 0, 0, 32'h0000_00FF, 0, LAT+1));
    vecs.push_back(mk(0, 3'd5, 32'h0000_0010, 0, 0, 32'h0000_00FF, 0, LAT+1));
    vecs.push_back(mk(0, 3'd2, 32'h0000_0010, 0, 0, 32'h8000_00FF, 0, LAT+1));
    vecs.push_back(mk(0, 3'd0, 32'h0000_0013, 0, 0, 32'hFFFF_FF80, 0, LAT+1));
    vecs.push_back(mk(0, 3'd5, 32'h0000_0012, 0, 0, 32'h0000_8000, 0, LAT+1));
    vecs.push_back(mk(0, 3'd1, 32'h0000_0012, 0, 0, 32'hFFFF_8000, 0, LAT+1));
    vecs.push_back(mk(1, 3'd0, 32'h0000_7023, 32'h1234_56AB, 0, 0, 0, 1));
    vecs.push_back(mk(0, 3'd2, 32'h0000_7020, 0, 0, 32'hAB00_0000, 0, 1));
    vecs.push_back(mk(1, 3'd2, 32'h0000_704C, 32'h0000_1234, 0, 0, 0, 1));
    vecs.push_back(mk(0, 3'd2, 32'h0000_704C, 0, 0, 32'h0000_1234, 0, 1));
    vecs.push_back(mk(0, 3'd2, 32'h0000_0002, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 3'd1, 32'h0000_7011, 32'h0000_FFFF, 0, 0, 1, 1));
    vecs.push_back(mk(0, 3'd2, 32'h0000_7010, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 3'd2, 32'h0000_0000, 0, 0, 32'h1122_3344, 0, LAT+1));
    vecs.push_back(mk(0, 3'd2, 32'h0000_7800, 0, 32'h0000_0F0F, 32'h0000_0F0F, 0, 1));
    vecs.push_back(mk(0, 3'd0, 32'h0000_7801, 0, 32'h0000_8F0F, 32'hFFFF_FF8F, 0, 1));
    vecs.push_back(mk(1, 3'd2, 32'h0000_7800, 32'hFFFF_FFFF, 0, 0, 0, 1));
    vecs.push_back(mk(1, 3'd2, 32'h0001_7000, 32'hDEAD_BEEF, 0, 0, 0, 1));
    vecs.push_back(mk(0, 3'd2, 32'h0000_7000, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 3'd2, 32'h0001_7000, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 3'd3, 32'h0000_0010, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 3'd4, 32'h0000_0010, 32'h1, 0, 0, 1, 1));
    vecs.push_back(mk(0, 3'd2, 32'h0000_7050, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 3'd2, 32'h0000_1000, 32'h0000_0001, 0, 0, 0, 1));
    vecs.push_back(mk(0, 3'd2, 32'h0000_1000, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 3'd2, 32'h0000_0000, 0, 0, 32'h1122_3344, 0, LAT+1));
    vecs.push_back(mk(1, 3'd1, 32'h0000_0012, 32'h0000_BEEF, 0, 0, 0, 1));
    vecs.push_back(mk(1, 3'd0, 32'h0000_0011, 32'h0000_005A, 0, 0, 0, 1));
    vecs.push_back(mk(0, 3'd2, 32'h0000_0010, 0, 0, 32'hBEEF_5AFF, 0, LAT+1));

    foreach (vecs[i]) begin
      model_req(vecs[i].we, vecs[i].op, vecs[i].addr, vecs[i].wd, vecs[i].swv, ed, ee, el);
      run($sformatf("vec%0d", i), vecs[i].we, vecs[i].op, vecs[i].addr, vecs[i].wd,
          vecs[i].swv, vecs[i].exp_d, vecs[i].exp_e, vecs[i].exp_l);
    end
    check_io("vec");

    // DMEM load holds ready low from T+1 through the response cycle.
    do_req(1'b0, 3'd2, 32'h0000_0010, 0, 0, rd, er, lat, busy);
    check("busy.cycles", busy, LAT + 1);
    check("busy.data", rd, 32'hBEEF_5AFF);

    // Reset during a pending DMEM load: no response, IO cleared, DMEM kept.
    run("pre_rst.ledr", 1'b1, 3'd2, 32'h0000_7000, 32'hCAFE_0001, 0, 0, 0, 1);
    void'(m_io.exists(32'h7000));
    m_io[32'h7000] = 32'hCAFE_0001;
    check("pre_rst.ledr_out", ledr, 32'hCAFE_0001);
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b0;
    bus.ls_op_i     = 3'd2;
    bus.addr_i      = 32'h0000_0010;
    @(posedge clk);
    #1 bus.req_valid_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_ni = 1'b0;
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.rsp_valid_o) seen++;
    end
    rst_ni = 1'b1;
    model_reset();
    repeat (8) begin
      @(negedge clk);
      if (bus.rsp_valid_o) seen++;
    end
    check("midrst.no_rsp", seen, 0);
    check("midrst.ready", 32'(bus.req_ready_o), 32'd1);
    check_io("midrst");
    run("midrst.dmem_kept", 1'b0, 3'd2, 32'h0000_0010, 0, 0, 32'hBEEF_5AFF, 0, LAT+1);

    // Randomized traffic against the model; initialise the DMEM window first.
    for (int wi = 0; wi < 16; wi++) begin
      logic [31:0] d;
      d = $urandom;
      model_req(1'b1, 3'd2, 32'(4*wi), d, 0, ed, ee, el);
      run($sformatf("init%0d", wi), 1'b1, 3'd2, 32'(4*wi), d, 0, ed, ee, el);
    end
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a, d, s;
      logic [2:0] op;
      logic we;
      case ($urandom_range(0, 5))
        0, 1:    a = 32'($urandom_range(0, 63));
        2:       a = 32'h7000 + 32'($urandom_range(0, 32'h9F));
        3:       a = 32'h7800 + 32'($urandom_range(0, 7));
        4:       a = 32'h1000 + 32'($urandom_range(0, 32'hFF));
        default: a = {16'($urandom_range(1, 32'hFFFF)), 16'($urandom_range(0, 63))};
      endcase
      op = 3'($urandom_range(0, 7));
      we = 1'($urandom_range(0, 1));
      d  = $urandom;
      s  = $urandom;
      model_req(we, op, a, d, s, ed, ee, el);
      run($sformatf("rnd%0d", n), we, op, a, d, s, ed, ee, el);
    end
    check_io("rnd");
    check("rsp_idle_zero", idle_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lsu_mmio_mc.md
Name: lsu_mmio_mc

Overview:
- Parametrised, multi-cycle load/store unit for the next-generation RV32I core.
- Replaces the single-cycle memory control path with a valid/ready request and a single-cycle response pulse.
- Contains the data memory, the memory-mapped LED/LCD/HEX output registers (HEX channel count configurable) and the switch input.
- Supports a data-memory read latency of 1 to 4 cycles and reports misaligned or illegal accesses instead of corrupting state.

Parameters:
- DMEM_AW, 10, word-address width of the data memory (2^DMEM_AW 32-bit words; default 4 KiB).
- NUM_HEX, 8, number of 32-bit HEX output registers (1..16).
- RD_LATENCY, 1, data-memory load latency in cycles (1..4).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  unit can accept a request.
- req_we_i  in  1  1 = store, 0 = load.
- ls_op_i  in  3  RV32 funct3 (load: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; store: 000 sb, 001 sh, 010 sw).
- addr_i  in  32  byte address.
- st_data_i  in  32  store data, right-aligned.
- rsp_valid_o  out  1  one-cycle response pulse.
- rsp_data_o  out  32  load result, extended per ls_op_i; 0 for stores and errors.
- rsp_err_o  out  1  misaligned or illegal access; qualified by rsp_valid_o.
- sw_i  in  32  switch inputs.
- io_ledr_o, io_ledg_o, io_lcd_o  out  32 each  output registers.
- io_hex_o  out  32*NUM_HEX  HEX registers; channel i occupies bits [32i+31:32i].

Behaviour:
- Reset: clock and reset as decided — one clock, clk_i; reset rst_ni is asynchronous, active-low. On reset: state IDLE, req_ready_o=1, rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0, all IO registers 0. Data memory contents are not reset.
- Address map, decoded on addr_i[15:0]; addr_i[31:16] must be 0, otherwise the address is unmapped:
  - 0x0000 to 4*2^DMEM_AW-1: DMEM.
  - 0x7000: LEDR.
  - 0x7010: LEDG.
  - 0x7020+4i: HEX i, for i<NUM_HEX.
  - 0x7080: LCD.
  - 0x7800: SW (read-only).
- Unmapped addresses: loads return 0, stores are ignored, rsp_err_o=0. Stores to SW are ignored.
- Accept: a request is taken at edge T when req_valid_i && req_ready_o. All request fields are captured at T, including a sample of sw_i. req_ready_o is 1 only in IDLE, so at most one request is outstanding.
- FSM:
  - IDLE → RESP on accept of a store, an IO/unmapped load, or an error.
  - IDLE → WAIT on accept of a DMEM load; a counter is loaded with RD_LATENCY-1.
  - WAIT: decrement the counter each cycle; → RESP when it reaches 0.
  - RESP: rsp_valid_o=1 for exactly one cycle, then → IDLE (ready again in the following cycle).
- Latency: stores, IO loads and errors respond in cycle T+1. DMEM loads respond in cycle T+1+RD_LATENCY. There is no response back-pressure.
- Stores: byte-enable writes into DMEM or IO registers at edge T. sb writes lane addr[1:0]; sh writes lanes {addr[1],0} and {addr[1],1}; sw writes all lanes. Lanes not enabled are unchanged.
- Loads: the lane is selected by addr[1:0]. lb/lh sign-extend; lbu/lhu zero-extend; lw returns the word unchanged.
- Errors: lh/lhu/sh with addr[0]=1, lw/sw with addr[1:0]≠0, or an undefined ls_op_i (load 011/110/111, store 011 and above). Effect: no write, rsp_err_o=1, rsp_data_o=0, response at T+1.
- rsp_data_o and rsp_err_o are valid only while rsp_valid_o=1 and are held at 0 otherwise.
- Reset asserted mid-operation: the pending load is aborted and no response is issued. DMEM writes already committed remain.
- Back-to-back operation: a store at T followed by a load of the same address accepted at T+2 returns the stored data (write-then-read ordering).

Test Plan:
- Reset held, then released → req_ready_o=1, rsp_valid_o=0, io_hex_o all 0, io_ledr_o=0.
- sw 0x8000_00FF to 0x0010 at T, then lb, lbu, lh, lhu, lw at 0x0010 → each responds after RD_LATENCY+1 cycles with 0xFFFFFFFF, 0x000000FF, 0x000000FF, 0x000000FF, 0x800000FF. Repeat with RD_LATENCY=3 and check req_ready_o is 0 for cycles T+1..T+4.
- sb 0xAB to 0x7023 then lw 0x7020 → io_hex_o[31:0]=0xAB000000, response 0xAB000000 at T+1. With NUM_HEX=12, sw 0x1234 to 0x704C → only channel 11 changes.
- lw 0x0002 and sh 0x7011 → response at T+1 with rsp_err_o=1, rsp_data_o=0; the memory word and LEDG are unchanged.
- sw_i=0x0000_0F0F, lw 0x7800 → 0x00000F0F. sw to 0x7800 and to 0x0001_7000 → no state change, rsp_err_o=0.
- DMEM load accepted with RD_LATENCY=4, rst_ni pulsed low at T+2 → no rsp_valid_o pulse; req_ready_o=1 after release; IO registers are 0.
